operand_entry_ctrl: RTL
=======================

Name: operand_entry_ctrl

Overview:
Front-end stage that feeds the sequential booth multiplier/display block from board I/O. A single push button, debounced on-chip, steps a four-phase entry sequence: capture multiplicand from the switches, then capture multiplier, then issue a one-cycle active-low start strobe. The block then waits for the multiplier's ready, and the next press begins a new operation. Operand outputs stay stable from capture until the next operation begins.

Parameters:
WIDTH, 5, operand width in bits; switches, multiplier and multiplicand are all this width; two's-complement signed.
DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles (en=1) required to accept a button level change; 10 ms at 50 MHz.
CHECK_PARAM, 1, when 1, $fatal at elaboration if WIDTH==0 or DEBOUNCE_CYCLES<2.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  global enable; 0 freezes all state, counters and outputs.
btn_n  in  1  raw push button, active-low, asynchronous to clk, bouncy.
switches  in  WIDTH  raw operand switches; sampled only at capture.
ready  in  1  multiplier done flag from the downstream multiplier.
multiplicand  out  WIDTH  registered operand A.
multiplier  out  WIDTH  registered operand B.
start_n  out  1  active-low start strobe, exactly one clk cycle wide.
phase  out  2  current FSM state encoding, for LEDs.

Behaviour:
- Reset (async, rst_n=0): state=LOAD_A, multiplicand=0, multiplier=0, start_n=1, phase=2'd0. Synchronizer flops reset to 1 (released). Debounced level resets to 1 and the debounce counter to 0.
- Input path: 2-flop synchronizer on btn_n. The debouncer counts while the synced level differs from the debounced level, and clears the count whenever they match. When the count reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced level flips and the counter clears.
- press = one-cycle pulse on a debounced 1->0 transition. A held button yields one press only. The release must also pass the debounce before another press can occur.
- Press latency: a clean edge on btn_n produces press 2 (sync) + DEBOUNCE_CYCLES cycles later.
- FSM states (phase encoding):
  - LOAD_A (0): on press, multiplicand<=switches, then go to LOAD_B.
  - LOAD_B (1): on press, multiplier<=switches, then go to START.
  - START (2): start_n=0 for this single cycle only, then go to BUSY unconditionally.
  - BUSY (3): the first cycle in BUSY ignores ready, to mask a stale ready from the previous operation. From the second cycle on, ready=1 moves the FSM to DONE. Presses in BUSY are discarded.
  - DONE (3): on press, go to LOAD_A. Operands are held, so the display keeps the result until the next capture.
- phase reports 3 for both BUSY and DONE.
- start_n is registered, never glitches, and is 1 in every state except START.
- Operands change only on the capture press in LOAD_A or LOAD_B. They are never cleared except by reset.
- en=0: synchronizer, debouncer, FSM and outputs all hold. If en drops while in START, start_n stays 0 until en returns, and the FSM then advances. This is legal because the multiplier shares en.
- A press coinciding with a state transition is consumed by the current state only. Press pulses are never queued.
- Reset mid-operation: immediate return to the reset values above, regardless of button or ready.

Decomposition:
- operand_entry_pkg: typedef enum logic [2:0] entry_state_t {LOAD_A, LOAD_B, START, BUSY, DONE}, plus function get_cnt_width(n) returning $clog2(n).
- Sub-module button_debouncer #(DEBOUNCE_CYCLES)(clk, rst_n, en, btn_n, level, press). It contains the synchronizer, the counter, and the falling-edge pulse generation.
- The top level holds the FSM, the operand registers and the phase decode.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=5):
1. Reset, then a clean press with switches=5'b00011 -> press 6 cycles after the btn_n fall; multiplicand=3; phase=1; multiplier=0.
2. Second press with switches=5'b11110 (-2) -> multiplier=5'b11110. One cycle later start_n=0 for exactly 1 cycle, and phase=2 during that cycle.
3. ready held 1 throughout START and BUSY entry -> FSM stays in BUSY for at least 1 cycle before DONE. Pulse ready 0 then 1 at cycle 5 -> DONE (phase=3) the cycle after.
4. Bounce: btn_n toggles every 2 cycles for 20 cycles, then settles low -> exactly one press, 6 cycles after settling. Holding btn_n low for 100 cycles -> no further press.
5. en=0 for 10 cycles during a press and during START -> debounce count and start_n frozen; start_n stays 0 for the whole en-low window and returns to 1 one cycle after en=1.
6. Assert rst_n=0 asynchronously in BUSY (mid-clock) -> outputs are 0/0, start_n=1 and phase=0 before the next clk edge. A press in DONE returns to LOAD_A with operands held.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// Shared types and helpers for the operand entry front-end.
package operand_entry_pkg;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        START  = 3'd2,
        BUSY   = 3'd3,
        DONE   = 3'd4
    } entry_state_t;

    // Counter width able to hold 0..n-1.
    function automatic int get_cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/operand_entry_ctrl_if.sv
// Board-side bundle: button/switch/ready inputs, operands/strobe/phase outputs.
interface operand_entry_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic             btn_n;
    logic [WIDTH-1:0] switches;
    logic             ready;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             start_n;
    logic [1:0]       phase;

    modport master (
        input  en, btn_n, switches, ready,
        output multiplicand, multiplier, start_n, phase
    );

    modport slave (
        output en, btn_n, switches, ready,
        input  multiplicand, multiplier, start_n, phase
    );
endinterface

// File: rtl/operand_entry_ctrl_debouncer.sv
// Button synchronizer + debouncer; emits a one-cycle press on a debounced fall.
module button_debouncer
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic btn_n,
    output logic level,
    output logic press
);
    localparam int            CW      = get_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mismatch;

    assign mismatch = (sync2_q != level_q);

    // Count consecutive mismatch cycles; flip the level once the run is long enough.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (mismatch) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce state; everything holds while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else if (en) begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
endmodule

// File: rtl/operand_entry_ctrl.sv
// Operand entry FSM: capture A, capture B, strobe start, wait for ready.
module operand_entry_ctrl
    import operand_entry_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit CHECK_PARAM     = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    operand_entry_ctrl_if.master bus
);
    if (CHECK_PARAM && (WIDTH == 0 || DEBOUNCE_CYCLES < 2)) begin : g_bad_param
        $fatal(1, "operand_entry_ctrl: illegal WIDTH/DEBOUNCE_CYCLES");
    end

    logic btn_level, btn_press, press_ok;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .btn_n (bus.btn_n),
        .level (btn_level),
        .press (btn_press)
    );

    // A press is only meaningful while the debounced button is down.
    assign press_ok = btn_press & ~btn_level;

    entry_state_t     state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             start_n_q;
    logic             busy_seen_q;

    // Next state and operand capture; BUSY ignores ready on its first cycle.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            LOAD_A: if (press_ok) begin
                mcand_d = bus.switches;
                state_d = LOAD_B;
            end
            LOAD_B: if (press_ok) begin
                mplier_d = bus.switches;
                state_d  = START;
            end
            START:  state_d = BUSY;
            BUSY:   if (busy_seen_q && bus.ready) state_d = DONE;
            DONE:   if (press_ok) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    // State, operands and registered start strobe; frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            mcand_q     <= '0;
            mplier_q    <= '0;
            start_n_q   <= 1'b1;
            busy_seen_q <= 1'b0;
        end else if (bus.en) begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            start_n_q   <= (state_d != START);
            busy_seen_q <= (state_q == BUSY);
        end
    end

    // LED phase: BUSY and DONE share code 3.
    always_comb begin
        case (state_q)
            LOAD_A:  bus.phase = 2'd0;
            LOAD_B:  bus.phase = 2'd1;
            START:   bus.phase = 2'd2;
            default: bus.phase = 2'd3;
        endcase
    end

    assign bus.multiplicand = mcand_q;
    assign bus.multiplier   = mplier_q;
    assign bus.start_n      = start_n_q;
endmodule
